// File: rtl/fp32_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fp32_pkg
// Purpose  : Shared FP32 field widths, canonical NaN, NaN test and the state
//            encoding used by the vector min/max reduction stage.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package fp32_pkg;

    localparam int FP32_K_WIDTH = 32;
    localparam int FP32_E_WIDTH = 8;
    localparam int FP32_M_WIDTH = 23;

    localparam logic [FP32_K_WIDTH-1:0] FP32_QNAN = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    // NaN: all-ones exponent with a non-zero mantissa (infinity excluded).
    function automatic logic is_nan(input logic [FP32_K_WIDTH-1:0] x);
        logic [FP32_E_WIDTH-1:0] e;
        logic [FP32_M_WIDTH-1:0] m;
        e = x[FP32_M_WIDTH +: FP32_E_WIDTH];
        m = x[FP32_M_WIDTH-1:0];
        return (e == {FP32_E_WIDTH{1'b1}}) && (m != '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp32_minmax_pick.sv
`default_nettype none
// ============================================================================
// Module   : fp32_minmax_pick
// Purpose  : Combinational selector returning max(a,b) or min(a,b) under a
//            sign-magnitude total order (-0 < +0, denormals by raw magnitude).
//            Bit-identical inputs return a.
// Ports    : a      - accumulator value (kept on ties)
//            b      - candidate value
//            is_max - 1 selects max, 0 selects min
//            y      - selected value
// Revision : 1.0 - initial release
// ============================================================================
module fp32_minmax_pick
    import fp32_pkg::*;
(
    input  logic [FP32_K_WIDTH-1:0] a,
    input  logic [FP32_K_WIDTH-1:0] b,
    input  logic                    is_max,
    output logic [FP32_K_WIDTH-1:0] y
);

    // Map sign-magnitude onto an unsigned key whose natural order matches
    // the float order: negatives are inverted, positives get the MSB set.
    // This places -0 (0x7FFFFFFF) just below +0 (0x80000000).
    function automatic logic [FP32_K_WIDTH-1:0] order_key(input logic [FP32_K_WIDTH-1:0] x);
        return x[FP32_K_WIDTH-1] ? ~x : (x | {1'b1, {(FP32_K_WIDTH-1){1'b0}}});
    endfunction

    logic [FP32_K_WIDTH-1:0] w_key_a;
    logic [FP32_K_WIDTH-1:0] w_key_b;
    logic                    w_b_gt;
    logic                    w_b_lt;

    assign w_key_a = order_key(a);
    assign w_key_b = order_key(b);
    assign w_b_gt  = (w_key_b > w_key_a);
    assign w_b_lt  = (w_key_b < w_key_a);

    assign y = (is_max ? w_b_gt : w_b_lt) ? b : a;

endmodule
`default_nettype wire

// File: rtl/fp32_vec_minmax_reduce.sv
`default_nettype none
// ============================================================================
// Module   : fp32_vec_minmax_reduce
// Purpose  : Streaming FP32 max/min reduction, one element per cycle, one
//            result per vector. NaN anywhere in a vector is sticky and yields
//            the canonical NaN. Vectors are force-ended at MAX_LEN elements.
// Ports    : clk, rstn          - clock, async active-low reset
//            i_is_max           - mode, sampled on a vector's first element
//            s_valid/ready/data/last - element stream in
//            m_valid/ready      - result handshake
//            m_data, m_nan, m_len, m_trunc - result fields
// Revision : 1.0 - initial release
// ============================================================================
module fp32_vec_minmax_reduce
    import fp32_pkg::*;
#(
    parameter int MAX_LEN = 256,
    parameter int CNT_W   = $clog2(MAX_LEN + 1)
)(
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    i_is_max,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [FP32_K_WIDTH-1:0] s_data,
    input  logic                    s_last,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [FP32_K_WIDTH-1:0] m_data,
    output logic                    m_nan,
    output logic [CNT_W-1:0]        m_len,
    output logic                    m_trunc
);

    state_t                  r_state;
    state_t                  w_state_next;
    logic [FP32_K_WIDTH-1:0] r_acc;
    logic                    r_mode;
    logic [CNT_W-1:0]        r_count;
    logic                    r_nan;

    logic                    w_accept;
    logic                    w_start;
    logic [FP32_K_WIDTH-1:0] w_pick;
    logic [FP32_K_WIDTH-1:0] w_acc_next;
    logic [CNT_W-1:0]        w_cnt_next;
    logic                    w_nan_next;
    logic                    w_end;

    assign m_valid  = (r_state == S_HOLD);
    // A pending result blocks input only while downstream is stalled, so a
    // draining result and a new element can share a cycle.
    assign s_ready  = !(m_valid && !m_ready);
    assign w_accept = s_valid && s_ready;

    // Any accept outside S_ACC opens a new vector (from idle, or from hold
    // while the previous result drains).
    assign w_start  = (r_state != S_ACC);

    fp32_minmax_pick u_pick (
        .a      (r_acc),
        .b      (s_data),
        .is_max (r_mode),
        .y      (w_pick)
    );

    assign w_acc_next = w_start ? s_data : w_pick;
    assign w_cnt_next = w_start ? CNT_W'(1) : (r_count + CNT_W'(1));
    assign w_nan_next = is_nan(s_data) | (!w_start & r_nan);
    assign w_end      = s_last || (w_cnt_next == CNT_W'(MAX_LEN));

    always_comb begin
        w_state_next = r_state;
        if (w_accept) begin
            w_state_next = w_end ? S_HOLD : S_ACC;
        end else if ((r_state == S_HOLD) && m_ready) begin
            w_state_next = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_mode  <= 1'b0;
            r_count <= '0;
            r_nan   <= 1'b0;
            m_data  <= '0;
            m_nan   <= 1'b0;
            m_len   <= '0;
            m_trunc <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_acc   <= w_acc_next;
                r_count <= w_cnt_next;
                r_nan   <= w_nan_next;
                if (w_start) begin
                    r_mode <= i_is_max;
                end
                if (w_end) begin
                    m_data  <= w_nan_next ? FP32_QNAN : w_acc_next;
                    m_nan   <= w_nan_next;
                    m_len   <= w_cnt_next;
                    m_trunc <= !s_last;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp32_vec_minmax_reduce.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp32_vec_minmax_reduce
// Purpose  : Directed self-checking bench for fp32_vec_minmax_reduce with
//            MAX_LEN=4 (CNT_W=3). Result fields are compared as one packed
//            word {m_valid, m_data, m_nan, m_len, m_trunc}.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp32_vec_minmax_reduce;

    localparam int MAX_LEN = 4;
    localparam int CNT_W   = 3;

    logic             clk;
    logic             rstn;
    logic             i_is_max;
    logic             s_valid;
    logic             s_ready;
    logic [31:0]      s_data;
    logic             s_last;
    logic             m_valid;
    logic             m_ready;
    logic [31:0]      m_data;
    logic             m_nan;
    logic [CNT_W-1:0] m_len;
    logic             m_trunc;

    int checks;
    int errors;

    fp32_vec_minmax_reduce #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .i_is_max (i_is_max),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .s_last   (s_last),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_nan    (m_nan),
        .m_len    (m_len),
        .m_trunc  (m_trunc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [37:0] obs;
    assign obs = {m_valid, m_data, m_nan, m_len, m_trunc};

    // Present one element and hold it until accepted; returns #1 after the
    // accepting edge with s_valid dropped.
    task automatic send(input logic [31:0] d, input logic last, input logic mx);
        int n;
        s_valid  = 1'b1;
        s_data   = d;
        s_last   = last;
        i_is_max = mx;
        n = 0;
        while (!s_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!s_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout data=%h s_ready stuck low", d);
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic drain();
        m_ready = 1'b1;
        @(posedge clk); #1;
        m_ready = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        #2;
        checks++;
        if (obs !== 38'd0) begin
            errors++; $display("FAIL reset_outputs got %h exp %h", obs, 38'd0);
        end
        @(posedge clk); @(posedge clk); #1;
        rstn = 1'b1;
        #1;
        checks++;
        if ({s_ready, m_valid} !== 2'b10) begin
            errors++; $display("FAIL reset_ready got %b exp %b", {s_ready, m_valid}, 2'b10);
        end
    endtask

    task automatic test_max();
        send(32'h3F800000, 1'b0, 1'b1);
        send(32'hC0000000, 1'b0, 1'b1);
        checks++;
        if (m_valid !== 1'b0) begin
            errors++; $display("FAIL max_early_valid got %b exp %b", m_valid, 1'b0);
        end
        send(32'h40600000, 1'b1, 1'b1);
        checks++;
        if (obs !== {1'b1, 32'h40600000, 1'b0, 3'd3, 1'b0}) begin
            errors++; $display("FAIL max_result got %h exp %h", obs, {1'b1, 32'h40600000, 1'b0, 3'd3, 1'b0});
        end
        drain();
        checks++;
        if (m_valid !== 1'b0) begin
            errors++; $display("FAIL max_drain got %b exp %b", m_valid, 1'b0);
        end
    endtask

    task automatic test_min_toggle();
        // Mode sampled as min on the first element; later i_is_max=1 ignored.
        send(32'h3F800000, 1'b0, 1'b0);
        send(32'hC0000000, 1'b0, 1'b1);
        send(32'h40600000, 1'b1, 1'b1);
        checks++;
        if (obs !== {1'b1, 32'hC0000000, 1'b0, 3'd3, 1'b0}) begin
            errors++; $display("FAIL min_toggle got %h exp %h", obs, {1'b1, 32'hC0000000, 1'b0, 3'd3, 1'b0});
        end
        drain();
    endtask

    task automatic test_nan();
        send(32'h3F800000, 1'b0, 1'b1);
        send(32'h7FC00000, 1'b0, 1'b1);
        send(32'h7F800000, 1'b1, 1'b1);
        checks++;
        if (obs !== {1'b1, 32'hFFFFFFFF, 1'b1, 3'd3, 1'b0}) begin
            errors++; $display("FAIL nan_result got %h exp %h", obs, {1'b1, 32'hFFFFFFFF, 1'b1, 3'd3, 1'b0});
        end
        drain();
    endtask

    task automatic test_signed_zero();
        send(32'h80000000, 1'b0, 1'b1);
        send(32'h00000000, 1'b1, 1'b1);
        checks++;
        if (obs !== {1'b1, 32'h00000000, 1'b0, 3'd2, 1'b0}) begin
            errors++; $display("FAIL zero_max got %h exp %h", obs, {1'b1, 32'h00000000, 1'b0, 3'd2, 1'b0});
        end
        drain();
        send(32'h80000000, 1'b0, 1'b0);
        send(32'h00000000, 1'b1, 1'b0);
        checks++;
        if (obs !== {1'b1, 32'h80000000, 1'b0, 3'd2, 1'b0}) begin
            errors++; $display("FAIL zero_min got %h exp %h", obs, {1'b1, 32'h80000000, 1'b0, 3'd2, 1'b0});
        end
        drain();
        send(32'h7F800000, 1'b1, 1'b1);
        checks++;
        if (obs !== {1'b1, 32'h7F800000, 1'b0, 3'd1, 1'b0}) begin
            errors++; $display("FAIL single_inf got %h exp %h", obs, {1'b1, 32'h7F800000, 1'b0, 3'd1, 1'b0});
        end
        drain();
    endtask

    task automatic test_backpressure();
        logic [31:0] vals [3];
        vals[0] = 32'h41000000;
        vals[1] = 32'hC1000000;
        vals[2] = 32'h3F000000;
        send(32'h3F800000, 1'b1, 1'b1);
        s_valid  = 1'b1;
        s_data   = 32'h40000000;
        s_last   = 1'b1;
        i_is_max = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({s_ready, m_valid, m_data} !== {1'b0, 1'b1, 32'h3F800000}) begin
                errors++; $display("FAIL stall_cycle%0d got %h exp %h", i, {s_ready, m_valid, m_data}, {1'b0, 1'b1, 32'h3F800000});
            end
            @(posedge clk); #1;
        end
        m_ready = 1'b1;
        #1;
        checks++;
        if (s_ready !== 1'b1) begin
            errors++; $display("FAIL release_ready got %b exp %b", s_ready, 1'b1);
        end
        @(posedge clk); #1;
        checks++;
        if (obs !== {1'b1, 32'h40000000, 1'b0, 3'd1, 1'b0}) begin
            errors++; $display("FAIL same_cycle_accept got %h exp %h", obs, {1'b1, 32'h40000000, 1'b0, 3'd1, 1'b0});
        end
        // Back-to-back single-element vectors with m_ready held high.
        for (int i = 0; i < 3; i++) begin
            s_data = vals[i];
            @(posedge clk); #1;
            checks++;
            if ({m_valid, m_data} !== {1'b1, vals[i]}) begin
                errors++; $display("FAIL b2b_%0d got %h exp %h", i, {m_valid, m_data}, {1'b1, vals[i]});
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        @(posedge clk); #1;
        m_ready = 1'b0;
        checks++;
        if (m_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_end got %b exp %b", m_valid, 1'b0);
        end
    endtask

    task automatic test_truncation();
        send(32'h3F800000, 1'b0, 1'b1);
        send(32'h40000000, 1'b0, 1'b1);
        send(32'h40400000, 1'b0, 1'b1);
        send(32'h40800000, 1'b0, 1'b1);
        checks++;
        if (obs !== {1'b1, 32'h40800000, 1'b0, 3'd4, 1'b1}) begin
            errors++; $display("FAIL trunc_first got %h exp %h", obs, {1'b1, 32'h40800000, 1'b0, 3'd4, 1'b1});
        end
        drain();
        send(32'h40A00000, 1'b0, 1'b0);
        send(32'h40C00000, 1'b1, 1'b0);
        checks++;
        if (obs !== {1'b1, 32'h40A00000, 1'b0, 3'd2, 1'b0}) begin
            errors++; $display("FAIL trunc_second got %h exp %h", obs, {1'b1, 32'h40A00000, 1'b0, 3'd2, 1'b0});
        end
        drain();
    endtask

    task automatic test_reset_mid();
        send(32'h41200000, 1'b0, 1'b1);
        send(32'h41300000, 1'b0, 1'b1);
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if (obs !== 38'd0) begin
            errors++; $display("FAIL async_reset got %h exp %h", obs, 38'd0);
        end
        @(posedge clk); #1;
        rstn = 1'b1;
        send(32'h40000000, 1'b0, 1'b0);
        send(32'h3F800000, 1'b1, 1'b0);
        checks++;
        if (obs !== {1'b1, 32'h3F800000, 1'b0, 3'd2, 1'b0}) begin
            errors++; $display("FAIL post_reset got %h exp %h", obs, {1'b1, 32'h3F800000, 1'b0, 3'd2, 1'b0});
        end
        drain();
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rstn     = 1'b0;
        i_is_max = 1'b0;
        s_valid  = 1'b0;
        s_data   = 32'h0;
        s_last   = 1'b0;
        m_ready  = 1'b0;
        test_reset();
        test_max();
        test_min_toggle();
        test_nan();
        test_signed_zero();
        test_backpressure();
        test_truncation();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fp32_vec_minmax_reduce.md
Name: fp32_vec_minmax_reduce

Overview:
Streaming reduction stage that consumes a vector of FP32 elements, one per cycle, and produces a single max or min result per vector. It uses the team's FP32 max/min ordering and NaN rule. It sits upstream of downstream result consumers and accepts element streams from the vector load path. Input and output use valid/ready handshakes, so the block can be dropped between buffered stages.

Parameters:
MAX_LEN, 256, maximum elements per vector; reaching it forces end-of-vector.
CNT_W, $clog2(MAX_LEN+1), derived; width of the element counter and m_len.

Ports:
clk  in  1  clock, rising edge
rstn  in  1  asynchronous active-low reset
i_is_max  in  1  1: max, 0: min; sampled only on a vector's first accepted element
s_valid  in  1  input element valid
s_ready  out  1  block can accept an element
s_data  in  32  FP32 element
s_last  in  1  final element of the vector
m_valid  out  1  result valid
m_ready  in  1  downstream accepts the result
m_data  out  32  reduced FP32 result
m_nan  out  1  a NaN was seen in the vector
m_len  out  CNT_W  number of elements reduced
m_trunc  out  1  vector was ended by MAX_LEN, not by s_last

Behaviour:
- Reset (async, rstn=0): state S_IDLE; m_valid=0, m_data=0, m_nan=0, m_len=0, m_trunc=0; count=0. s_ready is combinational and reads 1 once out of reset.
- Acceptance: an element is accepted when s_valid && s_ready.
- s_ready = !(m_valid && !m_ready). New input can be taken in the same cycle the pending result drains.
- States:
  - S_IDLE: no element held. On accept: acc<=s_data, mode<=i_is_max, count<=1, nan<=isNaN(s_data). Go to S_ACC, or to S_HOLD if s_last or MAX_LEN==1.
  - S_ACC: on accept: acc<=pick(acc, s_data, mode), count<=count+1, nan|=isNaN(s_data). Go to S_HOLD if s_last or count+1==MAX_LEN, otherwise stay.
  - S_HOLD: m_valid=1 and all outputs stable.
    - m_ready=1 with no accept: go to S_IDLE.
    - m_ready=1 with accept in the same cycle: the element starts a new vector (S_IDLE accept rules); m_valid stays 1 only if that element is also s_last.
- Output register load on the final-element cycle:
  - m_data <= nan_final ? 32'hFFFFFFFF : pick result.
  - m_nan <= nan_final.
  - m_len <= count_final.
  - m_trunc <= (!s_last).
- Latency: m_valid rises the cycle after the last element is accepted. Throughput is 1 element/cycle, with no bubble between vectors when m_ready=1.
- No element is accepted while in S_HOLD with m_ready=0; s_ready=0 in that case.
- NaN detection: exp==8'hFF && mant!=0. NaN is sticky for the whole vector, and the output is canonical 32'hFFFFFFFF.
- Ordering used by pick:
  - Sign-magnitude total order; -0 < +0; ±inf ordered normally; denormals compared as raw magnitude.
  - Ties (bit-identical values) keep the accumulator.
  - max: pick = (b > acc) ? b : acc. min: pick = (b < acc) ? b : acc.
- i_is_max is ignored after a vector's first element; mid-vector changes have no effect.
- Truncation: after a forced end, the next accepted element starts a new vector, even if the upstream has not yet asserted s_last.
- count never exceeds MAX_LEN and does not wrap.
- Reset mid-vector discards the partial accumulation and any pending result.

Decomposition:
- Shared package fp32_pkg:
  - field widths FP32_K_WIDTH=32, FP32_E_WIDTH=8, FP32_M_WIDTH=23
  - FP32_QNAN=32'hFFFFFFFF
  - isNaN function
  - state encoding constants S_IDLE/S_ACC/S_HOLD
- One combinational sub-module, fp32_minmax_pick:
  - inputs: a, b, is_max
  - output: selected value
  - implements the ordering above
  - reused by the compare stage.

Test Plan:
- Max: s_data 3F800000, C0000000, 40600000 (last), i_is_max=1 -> m_data=40600000, m_len=3, m_nan=0, m_trunc=0; m_valid one cycle after last accept.
- Min, same stream, i_is_max=0 -> m_data=C0000000. Toggle i_is_max after the first element -> result unchanged.
- NaN: 3F800000, 7FC00000, 7F800000 (last), max -> m_data=FFFFFFFF, m_nan=1.
- Signed zero: max {80000000, 00000000} -> 00000000; min -> 80000000. Single element 7F800000 (last) -> 7F800000, m_len=1.
- Backpressure:
  - Hold m_ready=0 for 3 cycles with result pending -> s_ready=0, m_data stable.
  - Then m_ready=1 with s_valid=1, s_data=40000000 -> new vector accepted that same cycle.
  - Back-to-back single-element vectors -> continuous m_valid.
- Truncation and reset, MAX_LEN=4:
  - 6 elements with no s_last -> first result m_len=4, m_trunc=1; remaining 2 start a new vector.
  - rstn pulsed low mid-vector -> all outputs 0, next vector reduces cleanly.
